pg_carry_ripple_adder: RTL and testbench

- N-bit binary adder built from prefix-style propagate/generate (PG) logic with a ripple group-PG chain: bitwise PG, serial group generate, sum XOR.
- Adder core is purely combinational; sum, carry-out and valid are registered once, so results appear one clock after the operands are sampled.
- Used as the baseline reference adder against which the parallel-prefix adders are compared.

---
 rtl/pg_adder_pkg.sv | 20 ++
 rtl/pg_gray_cell.sv | 12 +
 rtl/pg_carry_ripple_adder.sv | 91 +++++++++
 tb/tb_pg_carry_ripple_adder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pg_adder_pkg.sv
// Shared propagate/generate types and helpers for the PG adder family.
// Included by every adder top through import pg_adder_pkg::*.
package pg_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Black-cell merge of two adjacent PG spans, hi over lo.
    function automatic pg_t pg_combine(pg_t hi, pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/pg_gray_cell.sv
// Gray cell: group generate of a span from its upper bit PG and the
// generate of the span below it.
module pg_gray_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    output logic g_out
);

    assign g_out = g_hi | (p_hi & g_lo);

endmodule

// File: rtl/pg_carry_ripple_adder.sv
// Ripple-carry PG adder with one registered output stage.
// Define PG_RIPPLE_OVERFLOW_EN to add the registered signed-overflow port V.
module pg_carry_ripple_adder
    import pg_adder_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         out_valid
`ifdef PG_RIPPLE_OVERFLOW_EN
   ,output logic         V
`endif
);

    pg_t  [N-1:0] pg;
    logic [N-1:0] gg;
    logic [N-1:0] s_d;
    logic         cout_d;
    logic [N-1:0] s_q;
    logic         cout_q;
    logic         valid_q;

    // gg[k] is the carry into bit index k; gg[0] is Cin.
    assign gg[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign pg[i].g = A[i] & B[i];
        assign pg[i].p = A[i] ^ B[i];
        assign s_d[i]  = pg[i].p ^ gg[i];
    end

    for (genvar i = 1; i < N; i++) begin : g_chain
        pg_gray_cell u_gray (
            .g_hi  (pg[i-1].g),
            .p_hi  (pg[i-1].p),
            .g_lo  (gg[i-1]),
            .g_out (gg[i])
        );
    end

    pg_gray_cell u_cout (
        .g_hi  (pg[N-1].g),
        .p_hi  (pg[N-1].p),
        .g_lo  (gg[N-1]),
        .g_out (cout_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

`ifdef PG_RIPPLE_OVERFLOW_EN
    logic v_d;
    logic v_q;

    // Carry into the MSB differs from carry out of it.
    assign v_d = gg[N-1] ^ cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (in_valid) begin
            v_q <= v_d;
        end
    end

    assign V = v_q;
`endif

endmodule

// File: tb/tb_pg_carry_ripple_adder.sv
// Bench for pg_carry_ripple_adder at N=32 and N=8 against an
// arithmetic reference model.
module tb_pg_carry_ripple_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        cin, in_valid;
    logic [31:0] s;
    logic        cout, ovld;
    logic [7:0]  s8;
    logic        cout8, ovld8;
`ifdef PG_RIPPLE_OVERFLOW_EN
    logic        v, v8;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pg_carry_ripple_adder #(.N(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .in_valid  (in_valid),
        .S         (s),
        .Cout      (cout),
        .out_valid (ovld)
`ifdef PG_RIPPLE_OVERFLOW_EN
       ,.V         (v)
`endif
    );

    pg_carry_ripple_adder #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a8),
        .B         (b8),
        .Cin       (cin),
        .in_valid  (in_valid),
        .S         (s8),
        .Cout      (cout8),
        .out_valid (ovld8)
`ifdef PG_RIPPLE_OVERFLOW_EN
       ,.V         (v8)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic iv);
        @(negedge clk);
        a        = ia;
        b        = ib;
        a8       = ia[7:0];
        b8       = ib[7:0];
        cin      = ic;
        in_valid = iv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ovf(input logic sa, input logic sb,
                                 input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    initial begin
        logic [32:0] exp32;
        logic [8:0]  exp8;
        logic [31:0] ra, rb;
        logic        rc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; a8 = '0; b8 = '0; cin = 1'b0;
        #2;
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_valid", 64'(ovld), 64'd0);
        chk("rst_s8", 64'(s8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'd25, 32'd0, 1'b0, 1'b1);
        chk("add25_s", 64'(s), 64'd25);
        chk("add25_cout", 64'(cout), 64'd0);
        chk("add25_valid", 64'(ovld), 64'd1);
        drive(32'd25, 32'd75, 1'b0, 1'b1);
        chk("add100_s", 64'(s), 64'd100);
        chk("add100_valid", 64'(ovld), 64'd1);
        drive(32'd25, 32'd75, 1'b1, 1'b1);
        chk("add101_s", 64'(s), 64'd101);
        chk("add101_valid", 64'(ovld), 64'd1);

        drive(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        chk("wrap_s", 64'(s), 64'd0);
        chk("wrap_cout", 64'(cout), 64'd1);
        chk("wrap_s8", 64'(s8), 64'd0);
        chk("wrap_cout8", 64'(cout8), 64'd1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("ones_s", 64'(s), 64'hFFFF_FFFF);
        chk("ones_cout", 64'(cout), 64'd1);

        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'($urandom), 1'b0);
            chk("hold_s", 64'(s), 64'hFFFF_FFFF);
            chk("hold_cout", 64'(cout), 64'd1);
            chk("hold_valid", 64'(ovld), 64'd0);
        end

        drive(32'd1, 32'd2, 1'b0, 1'b1);
        chk("pre_rst_s", 64'(s), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s", 64'(s), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_valid", 64'(ovld), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_held_s", 64'(s), 64'd0);
            chk("rst_held_valid", 64'(ovld), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s", 64'(s), 64'd3);
        chk("post_rst_valid", 64'(ovld), 64'd1);

`ifdef PG_RIPPLE_OVERFLOW_EN
        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        chk("ovf_pos_s", 64'(s), 64'h8000_0000);
        chk("ovf_pos_v", 64'(v), 64'd1);
        chk("ovf_pos_cout", 64'(cout), 64'd0);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        chk("ovf_neg_s", 64'(s), 64'd0);
        chk("ovf_neg_v", 64'(v), 64'd1);
        chk("ovf_neg_cout", 64'(cout), 64'd1);
        drive(32'd5, 32'd6, 1'b0, 1'b0);
        chk("ovf_hold_v", 64'(v), 64'd1);
`endif

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            exp32 = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            exp8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + 9'(rc);
            drive(ra, rb, rc, 1'b1);
            chk("rnd32_sum", 64'({cout, s}), 64'(exp32));
            chk("rnd32_valid", 64'(ovld), 64'd1);
            chk("rnd8_sum", 64'({cout8, s8}), 64'(exp8));
`ifdef PG_RIPPLE_OVERFLOW_EN
            chk("rnd32_v", 64'(v), 64'(ovf(ra[31], rb[31], exp32[31])));
            chk("rnd8_v", 64'(v8), 64'(ovf(ra[7], rb[7], exp8[7])));
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
